// File: rtl/hwloop_ctrl.sv
// hwloop_ctrl -- hardware-loop controller for the OR10N ID stage.
//
// Compares the PC in ID against the armed loop end addresses, decides whether fetch must jump back
// to a loop start, and issues per-loop counter-decrement requests to the hwloop register file.
// Nested loops that share an end address are resolved innermost-first (index 0 is innermost).
// An EX-stage write to a loop set that is hitting in the same cycle raises a one-cycle stall; the
// following cycle re-evaluates against the updated registers.
//
// Optional feature: define HWLOOP_PERF_EN to build a saturating 32-bit counter of taken loop
// jumps. Without it hwloop_taken_cnt_o is tied to zero and no flops are built.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-high reset
//   current_pc_i         PC of the instruction in ID
//   instr_valid_i        ID holds a valid instruction
//   stall_id_i           ID stage stalled; finishing loops are not disarmed while set
//   flush_i              instruction in ID is being killed
//   hwloop_start_addr_i  loop start addresses, one per loop set
//   hwloop_end_addr_i    loop end addresses, one per loop set
//   hwloop_counter_i     current loop counters, one per loop set
//   hwloop_we_i          EX-stage write enables: [0] start, [1] end, [2] counter
//   hwloop_regid_i       loop set being written
//   hwloop_cnt_data_i    counter value being written
//   hwloop_jump_o        fetch must redirect to hwloop_targ_addr_o
//   hwloop_targ_addr_o   jump target (0 when no jump)
//   hwloop_dec_cnt_o     decrement request per loop set
//   hwloop_stall_o       write/decrement collision stall request
//   hwloop_taken_cnt_o   number of taken loop jumps (0 unless HWLOOP_PERF_EN)
module hwloop_ctrl #(
  parameter int unsigned N_LOOPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              current_pc_i,
  input  logic                     instr_valid_i,
  input  logic                     stall_id_i,
  input  logic                     flush_i,
  input  logic [N_LOOPS-1:0][31:0] hwloop_start_addr_i,
  input  logic [N_LOOPS-1:0][31:0] hwloop_end_addr_i,
  input  logic [N_LOOPS-1:0][31:0] hwloop_counter_i,
  input  logic [2:0]               hwloop_we_i,
  input  logic [1:0]               hwloop_regid_i,
  input  logic [31:0]              hwloop_cnt_data_i,
  output logic                     hwloop_jump_o,
  output logic [31:0]              hwloop_targ_addr_o,
  output logic [N_LOOPS-1:0]       hwloop_dec_cnt_o,
  output logic                     hwloop_stall_o,
  output logic [31:0]              hwloop_taken_cnt_o
);

  typedef enum logic [0:0] {StIdle, StRecheck} state_e;

  state_e state_q;

  logic [N_LOOPS-1:0] active_q, active_d;
  logic [N_LOOPS-1:0] hit;
  logic [N_LOOPS-1:0] cnt_ge2;
  logic [N_LOOPS-1:0] cnt_nz;
  logic [N_LOOPS-1:0] upto_sel;
  logic [N_LOOPS-1:0] regid_oh;
  logic               sel_found;
  logic [31:0]        sel_targ;
  logic               collision;

  // Per-loop hit and counter classification. flush_i masks every hit, which in turn zeroes jump,
  // dec and stall for the cycle.
  always_comb begin
    hit     = '0;
    cnt_ge2 = '0;
    cnt_nz  = '0;
    for (int i = 0; i < N_LOOPS; i++) begin
      hit[i]     = active_q[i] & instr_valid_i & ~flush_i &
                   (current_pc_i == hwloop_end_addr_i[i]);
      cnt_ge2[i] = hwloop_counter_i[i] >= 32'd2;
      cnt_nz[i]  = hwloop_counter_i[i] != 32'd0;
    end
  end

  // Innermost hitting loop with iterations left wins. upto_sel marks every index up to and
  // including the winner (all ones if nothing wins), so inner loops finishing on the same end
  // address are decremented alongside it.
  always_comb begin
    sel_found = 1'b0;
    sel_targ  = '0;
    upto_sel  = '0;
    for (int i = 0; i < N_LOOPS; i++) begin
      if (!sel_found) begin
        upto_sel[i] = 1'b1;
        if (hit[i] && cnt_ge2[i]) begin
          sel_found = 1'b1;
          sel_targ  = hwloop_start_addr_i[i];
        end
      end
    end
  end

  // A regid beyond N_LOOPS decodes to nothing, so it can neither collide nor arm.
  always_comb begin
    regid_oh = '0;
    for (int i = 0; i < N_LOOPS; i++) begin
      if (hwloop_regid_i == 2'(i)) begin
        regid_oh[i] = 1'b1;
      end
    end
  end

  assign collision = (|hwloop_we_i) & (|(hit & regid_oh));

  assign hwloop_stall_o     = collision;
  assign hwloop_jump_o      = sel_found & ~collision;
  assign hwloop_targ_addr_o = hwloop_jump_o ? sel_targ : 32'd0;
  // A hit with counter 0 is a spent loop: no decrement, just disarm.
  assign hwloop_dec_cnt_o   = collision ? '0 : (hit & cnt_nz & upto_sel);

  always_comb begin
    active_d = active_q;
    // Loops on their last (or a spent) iteration disarm once the instruction leaves ID.
    if (!stall_id_i && !collision) begin
      active_d = active_q & ~(hit & ~cnt_ge2);
    end
    // A counter write overrides any same-cycle disarm of that loop.
    if (hwloop_we_i[2]) begin
      active_d = (active_d & ~regid_oh) |
                 (regid_oh & {N_LOOPS{hwloop_cnt_data_i != 32'd0}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      active_q <= '0;
    end else begin
      active_q <= active_d;
      unique case (state_q)
        StIdle: begin
          if (collision) begin
            state_q <= StRecheck;
          end
        end
        StRecheck: begin
          // Re-evaluated against the updated registers; a repeat collision keeps us here.
          if (flush_i || !collision) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HWLOOP_PERF_EN
  logic [31:0] taken_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q <= '0;
    end else if (hwloop_jump_o && !stall_id_i && (taken_q != 32'hFFFF_FFFF)) begin
      taken_q <= taken_q + 32'd1;
    end
  end

  assign hwloop_taken_cnt_o = taken_q;
`else
  assign hwloop_taken_cnt_o = 32'd0;
`endif

endmodule
